// File: rtl/float_pkg.sv
// Shared definitions for the floating-point adder datapath: default widths,
// normalizer state encoding and the saturated exponent value.
package float_pkg;

  localparam int unsigned N_DEF   = 24;
  localparam int unsigned EXP_DEF = 8;

  localparam int unsigned EXP_MAX = (1 << EXP_DEF) - 1;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    SHIFT,
    DONE
  } norm_state_t;

  function automatic int unsigned exp_max(input int unsigned width);
    return (1 << width) - 1;
  endfunction

endpackage

// File: rtl/float_normalize.sv
// Iterative post-add normalizer: one right shift on carry-out or one left shift
// per cycle until the hidden bit is set, then holds the result for the rounder.
module float_normalize
  import float_pkg::*;
#(
  parameter int unsigned N   = N_DEF,
  parameter int unsigned EXP = EXP_DEF
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           start,
  input  logic [N+1:0]   sumMant,
  input  logic [EXP-1:0] sumExp,
  input  logic           sumSign,
  input  logic           stickyIn,
  input  logic           expNoDifIn,
  input  logic           mantNoDifIn,
  input  logic           ResultValid,
  output logic [N-1:0]   normMant,
  output logic [EXP-1:0] normExp,
  output logic           R,
  output logic           S,
  output logic           signOut,
  output logic           expNoDif,
  output logic           mantNoDif,
  output logic           validInput,
  output logic           busy,
  output logic           overflow,
  output logic           underflow
);

  localparam int unsigned   EW     = EXP + 1;
  localparam logic [EW-1:0] ExpSat = EW'(exp_max(EXP));
  localparam logic [EW-1:0] EOne   = EW'(1);

  norm_state_t r_state, w_state_nxt;

  // Working copies captured on start
  logic [N:0]     r_w, w_w_nxt;
  logic           r_carry, w_carry_nxt;
  logic [EW-1:0]  r_e, w_e_nxt;
  logic           r_sign, w_sign_nxt;
  logic           r_sticky, w_sticky_nxt;
  logic           r_exp_nd, w_exp_nd_nxt;
  logic           r_mant_nd, w_mant_nd_nxt;

  // Output registers, written only on entry to DONE or on clear
  logic [N-1:0]   r_mant, w_mant_nxt;
  logic [EXP-1:0] r_exp, w_exp_nxt;
  logic           r_r, w_r_nxt;
  logic           r_s, w_s_nxt;
  logic           r_sign_out, w_sign_out_nxt;
  logic           r_exp_nd_out, w_exp_nd_out_nxt;
  logic           r_mant_nd_out, w_mant_nd_out_nxt;
  logic           r_valid, w_valid_nxt;
  logic           r_ovf, w_ovf_nxt;
  logic           r_unf, w_unf_nxt;

  logic           w_go_done;
  logic [N:0]     w_w_shl;
  logic [EW-1:0]  w_e_inc;
  logic [EW-1:0]  w_e_dec;

  assign w_w_shl = {r_w[N-1:0], 1'b0};
  assign w_e_inc = r_e + EOne;
  assign w_e_dec = r_e - EOne;

  always_comb begin
    w_state_nxt       = r_state;
    w_w_nxt           = r_w;
    w_carry_nxt       = r_carry;
    w_e_nxt           = r_e;
    w_sign_nxt        = r_sign;
    w_sticky_nxt      = r_sticky;
    w_exp_nd_nxt      = r_exp_nd;
    w_mant_nd_nxt     = r_mant_nd;
    w_mant_nxt        = r_mant;
    w_exp_nxt         = r_exp;
    w_r_nxt           = r_r;
    w_s_nxt           = r_s;
    w_sign_out_nxt    = r_sign_out;
    w_exp_nd_out_nxt  = r_exp_nd_out;
    w_mant_nd_out_nxt = r_mant_nd_out;
    w_valid_nxt       = r_valid;
    w_ovf_nxt         = r_ovf;
    w_unf_nxt         = r_unf;
    w_go_done         = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_w_nxt       = sumMant[N:0];
          w_carry_nxt   = sumMant[N+1];
          w_e_nxt       = {1'b0, sumExp};
          w_sign_nxt    = sumSign;
          w_sticky_nxt  = stickyIn;
          w_exp_nd_nxt  = expNoDifIn;
          w_mant_nd_nxt = mantNoDifIn;
          w_state_nxt   = CHECK;
        end
      end

      CHECK: begin
        if (!r_carry && (r_w == '0)) begin
          w_mant_nxt = '0;
          w_exp_nxt  = '0;
          w_r_nxt    = 1'b0;
          w_s_nxt    = 1'b0;
          w_go_done  = 1'b1;
        end else if (r_carry) begin
          w_go_done = 1'b1;
          if (w_e_inc >= ExpSat) begin
            // Saturate to infinity; no rounding bits survive
            w_mant_nxt = '0;
            w_exp_nxt  = '1;
            w_r_nxt    = 1'b0;
            w_s_nxt    = 1'b0;
            w_ovf_nxt  = 1'b1;
          end else begin
            w_mant_nxt = {r_carry, r_w[N:2]};
            w_exp_nxt  = w_e_inc[EXP-1:0];
            w_r_nxt    = r_w[1];
            w_s_nxt    = r_w[0] | r_sticky;
          end
        end else if (r_w[N]) begin
          w_mant_nxt = r_w[N:1];
          w_exp_nxt  = r_e[EXP-1:0];
          w_r_nxt    = r_w[0];
          w_s_nxt    = r_sticky;
          w_go_done  = 1'b1;
        end else if (r_e <= EOne) begin
          w_mant_nxt = r_w[N:1];
          w_exp_nxt  = '0;
          w_r_nxt    = r_w[0];
          w_s_nxt    = r_sticky;
          w_unf_nxt  = 1'b1;
          w_go_done  = 1'b1;
        end else begin
          w_state_nxt = SHIFT;
        end
      end

      SHIFT: begin
        w_w_nxt = w_w_shl;
        w_e_nxt = w_e_dec;
        if (w_w_shl[N]) begin
          w_mant_nxt = w_w_shl[N:1];
          w_exp_nxt  = w_e_dec[EXP-1:0];
          w_r_nxt    = w_w_shl[0];
          w_s_nxt    = r_sticky;
          w_go_done  = 1'b1;
        end else if (w_e_dec == EOne) begin
          w_mant_nxt = w_w_shl[N:1];
          w_exp_nxt  = '0;
          w_r_nxt    = w_w_shl[0];
          w_s_nxt    = r_sticky;
          w_unf_nxt  = 1'b1;
          w_go_done  = 1'b1;
        end
      end

      DONE: begin
        if (ResultValid) begin
          w_mant_nxt        = '0;
          w_exp_nxt         = '0;
          w_r_nxt           = 1'b0;
          w_s_nxt           = 1'b0;
          w_sign_out_nxt    = 1'b0;
          w_exp_nd_out_nxt  = 1'b0;
          w_mant_nd_out_nxt = 1'b0;
          w_valid_nxt       = 1'b0;
          w_ovf_nxt         = 1'b0;
          w_unf_nxt         = 1'b0;
          w_state_nxt       = IDLE;
        end
      end

      default: w_state_nxt = IDLE;
    endcase

    if (w_go_done) begin
      w_sign_out_nxt    = r_sign;
      w_exp_nd_out_nxt  = r_exp_nd;
      w_mant_nd_out_nxt = r_mant_nd;
      w_valid_nxt       = 1'b1;
      w_state_nxt       = DONE;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state       <= IDLE;
      r_w           <= '0;
      r_carry       <= 1'b0;
      r_e           <= '0;
      r_sign        <= 1'b0;
      r_sticky      <= 1'b0;
      r_exp_nd      <= 1'b0;
      r_mant_nd     <= 1'b0;
      r_mant        <= '0;
      r_exp         <= '0;
      r_r           <= 1'b0;
      r_s           <= 1'b0;
      r_sign_out    <= 1'b0;
      r_exp_nd_out  <= 1'b0;
      r_mant_nd_out <= 1'b0;
      r_valid       <= 1'b0;
      r_ovf         <= 1'b0;
      r_unf         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_w           <= w_w_nxt;
      r_carry       <= w_carry_nxt;
      r_e           <= w_e_nxt;
      r_sign        <= w_sign_nxt;
      r_sticky      <= w_sticky_nxt;
      r_exp_nd      <= w_exp_nd_nxt;
      r_mant_nd     <= w_mant_nd_nxt;
      r_mant        <= w_mant_nxt;
      r_exp         <= w_exp_nxt;
      r_r           <= w_r_nxt;
      r_s           <= w_s_nxt;
      r_sign_out    <= w_sign_out_nxt;
      r_exp_nd_out  <= w_exp_nd_out_nxt;
      r_mant_nd_out <= w_mant_nd_out_nxt;
      r_valid       <= w_valid_nxt;
      r_ovf         <= w_ovf_nxt;
      r_unf         <= w_unf_nxt;
    end
  end

  assign normMant   = r_mant;
  assign normExp    = r_exp;
  assign R          = r_r;
  assign S          = r_s;
  assign signOut    = r_sign_out;
  assign expNoDif   = r_exp_nd_out;
  assign mantNoDif  = r_mant_nd_out;
  assign validInput = r_valid;
  assign overflow   = r_ovf;
  assign underflow  = r_unf;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_float_normalize.sv
// Self-checking bench for float_normalize: directed corner cases followed by
// random sums checked against an arithmetic leading-one reference model.
module tb_float_normalize;
  localparam int N   = 24;
  localparam int EXP = 8;

  logic           Clock = 1'b0;
  logic           Reset, start, sumSign, stickyIn, expNoDifIn, mantNoDifIn, ResultValid;
  logic [N+1:0]   sumMant;
  logic [EXP-1:0] sumExp;
  logic [N-1:0]   normMant;
  logic [EXP-1:0] normExp;
  logic           R, S, signOut, expNoDif, mantNoDif, validInput, busy, overflow, underflow;

  int checks = 0;
  int errors = 0;

  float_normalize #(.N(N), .EXP(EXP)) dut (
    .Clock(Clock), .Reset(Reset), .start(start), .sumMant(sumMant), .sumExp(sumExp),
    .sumSign(sumSign), .stickyIn(stickyIn), .expNoDifIn(expNoDifIn),
    .mantNoDifIn(mantNoDifIn), .ResultValid(ResultValid), .normMant(normMant),
    .normExp(normExp), .R(R), .S(S), .signOut(signOut), .expNoDif(expNoDif),
    .mantNoDif(mantNoDif), .validInput(validInput), .busy(busy), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [N-1:0]   mant;
    logic [EXP-1:0] exp;
    logic           r, s, ovf, unf, rs_known;
    int             lat;
  } exp_t;

  // Expected result: find the leading one and shift by arithmetic, stopping at exponent 1.
  function automatic exp_t model(input logic [N+1:0] sm, input logic [EXP-1:0] e,
                                 input logic st);
    exp_t m;
    int   ei  = int'(e);
    int   p   = -1;
    int   k;
    logic [N:0] w = sm[N:0];
    m.mant = '0; m.exp = '0; m.r = 0; m.s = 0; m.ovf = 0; m.unf = 0;
    m.rs_known = 1; m.lat = 2;
    if (sm == 0) return m;
    if (sm[N+1]) begin
      if (ei + 1 >= (1 << EXP) - 1) begin
        m.exp = '1; m.ovf = 1; m.rs_known = 0;
      end else begin
        m.mant = sm[N+1:2]; m.r = sm[1]; m.s = sm[0] | st; m.exp = EXP'(ei + 1);
      end
      return m;
    end
    for (int i = 0; i <= N; i++) if (w[i]) p = i;
    k = N - p;
    if (k == 0) begin
      m.mant = w[N:1]; m.r = w[0]; m.s = st; m.exp = e;
    end else if (ei <= 1) begin
      m.mant = w[N:1]; m.unf = 1; m.rs_known = 0;
    end else if (k <= ei - 1) begin
      w = w << k;
      m.mant = w[N:1]; m.r = w[0]; m.s = st; m.exp = EXP'(ei - k); m.lat = 2 + k;
    end else begin
      w = w << (ei - 1);
      m.mant = w[N:1]; m.unf = 1; m.rs_known = 0; m.lat = 1 + ei;
    end
    return m;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag, input exp_t m, input logic sg,
                              input logic en, input logic mn);
    check({tag, ".valid"}, 32'(validInput), 32'(1));
    check({tag, ".busy"}, 32'(busy), 32'(1));
    check({tag, ".mant"}, 32'(normMant), 32'(m.mant));
    check({tag, ".exp"}, 32'(normExp), 32'(m.exp));
    check({tag, ".ovf"}, 32'(overflow), 32'(m.ovf));
    check({tag, ".unf"}, 32'(underflow), 32'(m.unf));
    check({tag, ".flags"}, 32'({signOut, expNoDif, mantNoDif}), 32'({sg, en, mn}));
    if (m.rs_known) check({tag, ".RS"}, 32'({R, S}), 32'({m.r, m.s}));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".busy"}, 32'(busy), 32'(0));
    check({tag, ".outs"},
          32'({validInput, R, S, signOut, expNoDif, mantNoDif, overflow, underflow}), 32'(0));
    check({tag, ".mant"}, 32'(normMant), 32'(0));
    check({tag, ".exp"}, 32'(normExp), 32'(0));
  endtask

  // One transaction; inject pulses start/ResultValid mid-shift, hold delays ResultValid.
  task automatic run(input string tag, input logic [N+1:0] sm, input logic [EXP-1:0] e,
                     input logic sg, input logic st, input logic en, input logic mn,
                     input int hold, input bit inject);
    exp_t m = model(sm, e, st);
    int   cnt;
    @(negedge Clock);
    sumMant = sm; sumExp = e; sumSign = sg; stickyIn = st;
    expNoDifIn = en; mantNoDifIn = mn; start = 1;
    @(negedge Clock);
    start = 0; cnt = 1;
    sumMant = {$urandom, $urandom}; sumExp = EXP'($urandom);
    sumSign = ~sg; stickyIn = ~st; expNoDifIn = ~en; mantNoDifIn = ~mn;
    while (!validInput && cnt < 60) begin
      start       = inject && (cnt == 2);
      ResultValid = inject && (cnt == 2);
      @(negedge Clock);
      cnt++;
    end
    start = 0; ResultValid = 0;
    check({tag, ".latency"}, 32'(cnt), 32'(m.lat));
    check_result(tag, m, sg, en, mn);
    if (hold > 0) begin
      repeat (hold) @(negedge Clock);
      check_result({tag, ".held"}, m, sg, en, mn);
    end
    ResultValid = 1;
    @(negedge Clock);
    ResultValid = 0;
    check_cleared({tag, ".clear"});
  endtask

  initial begin
    logic [63:0]    rnd;
    logic [N+1:0]   sm;
    logic [EXP-1:0] e;
    Reset = 1; start = 0; sumMant = '0; sumExp = '0; sumSign = 0; stickyIn = 0;
    expNoDifIn = 0; mantNoDifIn = 0; ResultValid = 0;
    repeat (3) @(negedge Clock);
    check_cleared("reset");
    Reset = 0;

    run("carry", {1'b1, 24'h000001, 1'b1}, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run("aligned", {1'b0, 24'hC00000, 1'b0}, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run("shift3", {1'b0, 24'h100000, 1'b1}, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1);
    run("underflow", {1'b0, 24'h000010, 1'b0}, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run("chk_unf", {1'b0, 24'h000100, 1'b0}, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run("overflow", {1'b1, 24'h400000, 1'b0}, 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run("no_ovf", {1'b1, 24'h400000, 1'b0}, 8'hFD, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run("zero", '0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    run("hold5", {1'b0, 24'h000001, 1'b1}, 8'h90, 1'b1, 1'b1, 1'b0, 1'b1, 5, 1'b1);

    // Reset in the middle of a long shift
    @(negedge Clock);
    sumMant = {1'b0, 24'h000001, 1'b0}; sumExp = 8'h80; sumSign = 1; start = 1;
    @(negedge Clock);
    start = 0;
    repeat (2) @(negedge Clock);
    check("rst_shift.busy", 32'(busy), 32'(1));
    Reset = 1;
    @(negedge Clock);
    Reset = 0;
    check_cleared("rst_shift");

    for (int i = 0; i < 200; i++) begin
      rnd = {$urandom, $urandom};
      sm  = rnd[N+1:0] >> $urandom_range(0, N + 1);
      e   = EXP'($urandom);
      if ($urandom_range(0, 3) == 0) e = EXP'($urandom_range(0, 4));
      if ($urandom_range(0, 7) == 0) e = EXP'($urandom_range(250, 255));
      run("rand", sm, e, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          $urandom_range(0, 3), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/float_normalize.md
# float_normalize

Normalization stage that sits directly upstream of the FloatRounding block in the floating-point adder datapath. It accepts the raw post-add/subtract mantissa (with carry and guard bit), exponent and sign. It renormalizes the mantissa iteratively: one right shift on carry-out, or one left shift per cycle until the hidden bit is set. It then presents `normMant`/`normExp`/`R`/`S` with a held valid until the rounder reports `ResultValid`.

## Interface
- `N`, 24, mantissa width including hidden bit.
- `EXP`, 8, exponent width.

- `Clock`  in  1  clock.
- `Reset`  in  1  reset: synchronous, active-high.
- `start`  in  1  one-cycle pulse; sum inputs valid. Ignored unless `busy`=0.
- `sumMant`  in  N+2  {carry, mantissa[N-1:0], guard}; hidden-bit position is bit N.
- `sumExp`  in  EXP  exponent of the larger operand.
- `sumSign`  in  1  result sign.
- `stickyIn`  in  1  OR of bits shifted out during alignment.
- `expNoDifIn`, `mantNoDifIn`  in  1 each  equal-operand flags from the aligner.
- `ResultValid`  in  1  rounder has consumed the result.
- `normMant`  out  N  normalized mantissa.
- `normExp`  out  EXP  normalized exponent.
- `R`, `S`  out  1 each  round and sticky bits.
- `signOut`, `expNoDif`, `mantNoDif`  out  1 each  registered copies of the inputs.
- `validInput`  out  1  result valid to the rounder.
- `busy`  out  1  high in any state other than IDLE.
- `overflow`, `underflow`  out  1 each  exponent saturation flags, valid with `validInput`.

## Operation
- States: IDLE, CHECK, SHIFT, DONE.
- **IDLE**
  - On `start`: latch the work register W[N:0] = `sumMant`[N:0], the carry, and E = {1'b0, `sumExp`} (EXP+1 bits). Also latch sign, sticky and the NoDif flags. Go to CHECK.
- **CHECK**, first matching rule wins:
  - `sumMant`==0: output mant 0, exp 0, R=S=0 → DONE.
  - carry=1: mant = `sumMant`[N+1:2], R = `sumMant`[1], S = `sumMant`[0] | `stickyIn`, E+1.
    - If E+1 ≥ 2^EXP−1: exp = all-ones, mant 0, `overflow`=1.
    - → DONE.
  - W[N]=1 (already normalized): mant = W[N:1], R = W[0], S = `stickyIn` → DONE.
  - E ≤ 1: exp 0, mant = W[N:1], `underflow`=1 → DONE.
  - Otherwise → SHIFT.
- **SHIFT**, each cycle: W <= W<<1 (0 shifted in), E <= E−1.
  - If the new W[N]=1: mant = W[N:1], R = W[0], S = `stickyIn` → DONE.
  - Else if the new E==1: exp 0, mant = W[N:1], `underflow`=1 → DONE.
- **DONE**: `validInput`=1 with all outputs held stable. On `ResultValid`, clear everything next cycle → IDLE.
- `start` while `busy` is dropped and has no effect.
- Reset dominates all inputs. Reset in any state → IDLE next cycle, every output 0.

## Timing
- Reset values: every output 0; state IDLE.
- `start` at cycle t → CHECK at t+1.
- `validInput` at t+2 for the zero, carry, aligned and CHECK-underflow cases; at t+2+k for a k-bit left shift. Worst case t+2+N.
- `validInput` falls the cycle after `ResultValid` is sampled in DONE. Earliest next accepted `start` is that cycle.
- `ResultValid` outside DONE is ignored.
- Outputs change only on the transition into DONE or on clear.

## Structure
- Shared package `float_pkg`:
  - default `N`/`EXP` constants;
  - state enum `norm_state_t` (IDLE, CHECK, SHIFT, DONE);
  - localparam `EXP_MAX` = 2^EXP−1.
- No sub-module is needed: the single-bit iterative shifter and the exponent decrement stay inline.

## Test plan
- **Carry-out.** `sumMant`={1, 24'h000001, 1}, exp 8'h80, sticky 0 → at t+2: `normMant`=24'h800000, `normExp`=8'h81, R=1, S=1.
- **Aligned.** `sumMant`={0, 24'hC00000, 0}, exp 8'h7F, sticky 1 → at t+2: mant 24'hC00000, exp 8'h7F, R=0, S=1.
- **Left shift by 3.** `sumMant`={0, 24'h100000, 1}, exp 8'h80 → at t+5: mant 24'h800004, exp 8'h7D, R=0, S=0.
- **Underflow.** `sumMant`={0, 24'h000010, 0}, exp 8'h02 → at t+3: mant 24'h000020, exp 0, `underflow`=1.
- **Overflow and zero.**
  - Carry input with exp 8'hFE → exp 8'hFF, mant 0, `overflow`=1.
  - `sumMant`=0 with `expNoDifIn`=`mantNoDifIn`=1 → mant 0, exp 0, both flags passed through.
- **Handshake and reset.**
  - `start` during SHIFT is ignored.
  - Outputs are held in DONE for 5 cycles until `ResultValid`, then clear.
  - `Reset` during SHIFT → all outputs 0 and IDLE next cycle.
